// File: rtl/sprite_scroll_field.sv
// Scrolling background-sprite manager: spawns, moves and retires NUM_SLOTS sprites
// and resolves per-pixel coverage into a registered sprite-ROM address.
module sprite_scroll_field #(
  parameter int NUM_SLOTS   = 3,
  parameter int SPRITE_W    = 52,
  parameter int SPRITE_H    = 19,
  parameter int SPAWN_X     = 692,
  parameter int Y_BASE      = 240,
  parameter int RAND_W      = 7,
  parameter int SKIP_THRESH = 10,
  parameter int MIN_GAP     = 150,
  parameter int FULL_GAP    = 50,
  parameter int SKIP_GAP    = 80,
  parameter int ADDR_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_tick,
  input  logic                 run,
  input  logic                 clear,
  input  logic [RAND_W-1:0]    rand_in,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  output logic                 pix_valid,
  output logic [ADDR_W-1:0]    pix_addr,
  output logic [2:0]           pix_slot,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 spawn_pulse
);

  localparam logic [7:0]  GAP_MIN  = 8'(MIN_GAP);
  localparam logic [7:0]  GAP_FULL = 8'(FULL_GAP);
  localparam logic [7:0]  GAP_SKIP = 8'(SKIP_GAP);
  localparam logic [10:0] X_SPAWN  = 11'(SPAWN_X);
  localparam logic [9:0]  Y_BOT    = 10'(Y_BASE);
  localparam logic [11:0] W12      = 12'(SPRITE_W);
  localparam logic [11:0] H12      = 12'(SPRITE_H);
  localparam logic [31:0] SKIP_U   = 32'(SKIP_THRESH);

  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic [10:0]          x_q [NUM_SLOTS];
  logic [10:0]          x_d [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           y_d [NUM_SLOTS];
  logic [7:0]           gap_q, gap_d;
  logic                 spawn_q, spawn_d;

  logic                 pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0]    pix_addr_q, pix_addr_d;
  logic [2:0]           pix_slot_q, pix_slot_d;

  logic [NUM_SLOTS-1:0] free_onehot;
  logic                 all_busy;
  logic                 skip_hit;
  logic [9:0]           spawn_y;

  logic [NUM_SLOTS-1:0] hit;
  logic [11:0]          row_off [NUM_SLOTS];
  logic [11:0]          col_off [NUM_SLOTS];

  // Decisions always look at the pre-tick active flags, so a slot freed this tick stays unusable.
  assign free_onehot = ~act_q & (act_q + NUM_SLOTS'(1));
  assign all_busy    = &act_q;
  assign skip_hit    = 32'(rand_in) < SKIP_U;
  assign spawn_y     = Y_BOT - 10'(rand_in);

  always_comb begin
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    gap_d   = gap_q;
    spawn_d = 1'b0;
    if (clear) begin
      act_d = '0;
      gap_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_d[i] = '0;
        y_d[i] = '0;
      end
    end else if (move_tick) begin
      if (!run) begin
        gap_d = '0;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (act_q[i]) begin
            if (x_q[i] == 11'd0) act_d[i] = 1'b0;
            else                 x_d[i]   = x_q[i] - 11'd1;
          end
        end
        if (gap_q != GAP_MIN) begin
          gap_d = gap_q + 8'd1;
        end else if (all_busy) begin
          gap_d = GAP_FULL;
        end else if (skip_hit) begin
          gap_d = GAP_SKIP;
        end else begin
          gap_d   = '0;
          spawn_d = 1'b1;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free_onehot[i]) begin
              act_d[i] = 1'b1;
              x_d[i]   = X_SPAWN;
              y_d[i]   = spawn_y;
            end
          end
        end
      end
    end
  end

  // Offsets stay relative to the unclipped origin, so left-clipped sprites still address correctly.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit[i] = act_q[i]
            && ({2'b00, h_cnt} < {1'b0, x_q[i]})
            && ({2'b00, h_cnt} + W12 >= {1'b0, x_q[i]})
            && ({2'b00, v_cnt} < {2'b00, y_q[i]})
            && ({2'b00, v_cnt} + H12 >= {2'b00, y_q[i]});
      row_off[i] = {2'b00, v_cnt} + H12 - {2'b00, y_q[i]};
      col_off[i] = {2'b00, h_cnt} + W12 - {1'b0, x_q[i]};
    end
  end

  always_comb begin
    pix_valid_d = 1'b0;
    pix_addr_d  = '0;
    pix_slot_d  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pix_valid_d = 1'b1;
        pix_addr_d  = ADDR_W'(row_off[i] * W12 + col_off[i]);
        pix_slot_d  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q       <= '0;
      gap_q       <= '0;
      spawn_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      pix_slot_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      act_q       <= act_d;
      gap_q       <= gap_d;
      spawn_q     <= spawn_d;
      pix_valid_q <= pix_valid_d;
      pix_addr_q  <= pix_addr_d;
      pix_slot_q  <= pix_slot_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_addr    = pix_addr_q;
  assign pix_slot    = pix_slot_q;
  assign active_mask = act_q;
  assign spawn_pulse = spawn_q;

endmodule

// File: tb/tb_sprite_scroll_field.sv
// Self-checking bench for sprite_scroll_field: a slot-list reference model checks
// every cycle, plus directed spawn/skip/full/retire/pixel/overlap scenarios.
module tb_sprite_scroll_field;

  localparam int NS          = 3;
  localparam int W           = 52;
  localparam int H           = 19;
  localparam int SPAWN_X     = 692;
  localparam int Y_BASE      = 240;
  localparam int MIN_GAP     = 150;
  localparam int FULL_GAP    = 50;
  localparam int SKIP_GAP    = 80;
  localparam int SKIP_THRESH = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, move_tick, run, clear;
  logic [6:0]  rand_in;
  logic [9:0]  h_cnt, v_cnt;
  logic        pix_valid;
  logic [10:0] pix_addr;
  logic [2:0]  pix_slot;
  logic [2:0]  active_mask;
  logic        spawn_pulse;

  logic        b_rst, b_move, b_run, b_clear;
  logic [6:0]  b_rand;
  logic [9:0]  b_h, b_v;
  logic        b_valid;
  logic [10:0] b_addr;
  logic [2:0]  b_slot;
  logic [2:0]  b_mask;
  logic        b_spawn;

  sprite_scroll_field dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .run(run), .clear(clear),
    .rand_in(rand_in), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_slot(pix_slot),
    .active_mask(active_mask), .spawn_pulse(spawn_pulse)
  );

  // Short spawn interval so two sprites can be made to overlap horizontally.
  sprite_scroll_field #(.MIN_GAP(30)) dut2 (
    .clk(clk), .rst(b_rst), .move_tick(b_move), .run(b_run), .clear(b_clear),
    .rand_in(b_rand), .h_cnt(b_h), .v_cnt(b_v),
    .pix_valid(b_valid), .pix_addr(b_addr), .pix_slot(b_slot),
    .active_mask(b_mask), .spawn_pulse(b_spawn)
  );

  int checks = 0;
  int errors = 0;

  int m_act [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_gap;
  int e_valid, e_addr, e_slot, e_spawn;

  logic [18:0] obs_vec;
  assign obs_vec = {pix_valid, pix_addr, pix_slot, active_mask, spawn_pulse};

  function automatic logic [2:0] model_mask();
    logic [2:0] m;
    for (int i = 0; i < NS; i++) m[i] = (m_act[i] != 0);
    return m;
  endfunction

  function automatic logic [18:0] exp_vec();
    return {1'(e_valid), 11'(e_addr), 3'(e_slot), model_mask(), 1'(e_spawn)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_gap = 0;
  endtask

  task automatic model_pixel(input int h, input int v);
    bit found;
    found   = 0;
    e_valid = 0;
    e_addr  = 0;
    e_slot  = 0;
    for (int i = 0; i < NS; i++) begin
      if (!found && m_act[i] != 0 && h < m_x[i] && h >= m_x[i] - W && v < m_y[i] && v >= m_y[i] - H) begin
        found   = 1;
        e_valid = 1;
        e_addr  = ((v - (m_y[i] - H)) * W + (h - (m_x[i] - W))) % 2048;
        e_slot  = i;
      end
    end
  endtask

  task automatic model_tick(input bit mt, input bit rn, input bit cl, input int rnd);
    int pre [NS];
    int target;
    int busy;
    e_spawn = 0;
    target  = -1;
    busy    = 0;
    if (cl) begin
      model_reset();
    end else if (mt) begin
      if (!rn) begin
        m_gap = 0;
      end else begin
        pre = m_act;
        foreach (pre[i]) busy += pre[i];
        if (m_gap != MIN_GAP) m_gap++;
        else if (busy == NS) m_gap = FULL_GAP;
        else if (rnd < SKIP_THRESH) m_gap = SKIP_GAP;
        else begin
          for (int i = 0; i < NS; i++) if (pre[i] == 0 && target < 0) target = i;
          m_gap   = 0;
          e_spawn = 1;
        end
        for (int i = 0; i < NS; i++) begin
          if (pre[i] != 0) begin
            if (m_x[i] == 0) m_act[i] = 0;
            else m_x[i]--;
          end
        end
        if (target >= 0) begin
          m_act[target] = 1;
          m_x[target]   = SPAWN_X;
          m_y[target]   = Y_BASE - rnd;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input bit rs, input bit mt, input bit rn, input bit cl,
                                input int rnd, input int h, input int v);
    @(negedge clk);
    rst       = rs;
    move_tick = mt;
    run       = rn;
    clear     = cl;
    rand_in   = 7'(rnd);
    h_cnt     = 10'(h);
    v_cnt     = 10'(v);
    model_pixel(h, v);
    @(posedge clk);
    if (rs) begin
      model_reset();
      e_valid = 0;
      e_addr  = 0;
      e_slot  = 0;
      e_spawn = 0;
    end else begin
      model_tick(mt, rn, cl, rnd);
    end
    #1;
  endtask

  task automatic pick_probe(output int h, output int v);
    int k;
    if ($urandom_range(0, 3) == 0) begin
      h = int'($urandom_range(0, 799));
      v = int'($urandom_range(0, 524));
    end else begin
      k = int'($urandom_range(0, NS - 1));
      h = m_x[k] - int'($urandom_range(0, 54));
      v = m_y[k] - int'($urandom_range(0, 21));
      if (h < 0) h = 0;
      if (v < 0) v = 0;
    end
  endtask

  task automatic b_cycle(input bit rs, input bit mt, input int h, input int v);
    @(negedge clk);
    b_rst  = rs;
    b_move = mt;
    b_h    = 10'(h);
    b_v    = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_stimulus(1, 1, 1, 0, 77, 300, 200);
    apply_stimulus(1, 1, 1, 0, 12, 10, 10);
    checks++;
    if (obs_vec !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs_vec, 19'd0);
    end
    apply_stimulus(0, 0, 1, 0, 40, 0, 0);
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %h expected %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_spawn();
    int h, v;
    for (int t = 1; t <= 151; t++) begin
      pick_probe(h, v);
      apply_stimulus(0, 1, 1, 0, 40, h, v);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL spawn_tick%0d: got %h expected %h", t, obs_vec, exp_vec());
      end
      checks++;
      if (spawn_pulse !== (t == 151)) begin
        errors++;
        $display("[TB] FAIL spawn_pulse_tick%0d: got %b expected %b", t, spawn_pulse, t == 151);
      end
    end
    checks++;
    if (active_mask !== 3'b001) begin
      errors++;
      $display("[TB] FAIL spawn_mask: got %b expected 001", active_mask);
    end
    apply_stimulus(0, 0, 1, 0, 40, 691, 199);
    checks++;
    if ({pix_valid, pix_addr, pix_slot} !== {1'b1, 11'd987, 3'd0}) begin
      errors++;
      $display("[TB] FAIL spawn_pos_corner: got %b/%0d/%0d expected 1/987/0", pix_valid, pix_addr, pix_slot);
    end
    apply_stimulus(0, 0, 1, 0, 40, 640, 181);
    checks++;
    if ({pix_valid, pix_addr} !== {1'b1, 11'd0}) begin
      errors++;
      $display("[TB] FAIL spawn_pos_origin: got %b/%0d expected 1/0", pix_valid, pix_addr);
    end
  endtask

  task automatic test_skip();
    for (int t = 1; t <= 150; t++) begin
      apply_stimulus(0, 1, 1, 0, 40, 0, 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL skip_pre_tick%0d: got %h expected %h", t, obs_vec, exp_vec());
      end
    end
    apply_stimulus(0, 1, 1, 0, 5, 0, 0);
    checks++;
    if ({spawn_pulse, active_mask} !== {1'b0, 3'b001}) begin
      errors++;
      $display("[TB] FAIL skip_decision: got %b/%b expected 0/001", spawn_pulse, active_mask);
    end
    for (int t = 1; t <= 71; t++) begin
      apply_stimulus(0, 1, 1, 0, 40, 0, 0);
      checks++;
      if (spawn_pulse !== (t == 71)) begin
        errors++;
        $display("[TB] FAIL skip_regap_tick%0d: got %b expected %b", t, spawn_pulse, t == 71);
      end
    end
    checks++;
    if (active_mask !== 3'b011) begin
      errors++;
      $display("[TB] FAIL skip_second_spawn_mask: got %b expected 011", active_mask);
    end
  endtask

  task automatic test_full();
    int h, v;
    apply_stimulus(0, 0, 1, 1, 40, 0, 0);
    for (int t = 1; t <= 910; t++) begin
      pick_probe(h, v);
      apply_stimulus(0, 1, 1, 0, 40, h, v);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL full_tick%0d: got %h expected %h", t, obs_vec, exp_vec());
      end
      if (t == 604 || t == 705 || t == 806) begin
        checks++;
        if ({spawn_pulse, active_mask} !== {1'b0, 3'b111}) begin
          errors++;
          $display("[TB] FAIL full_decision_tick%0d: got %b/%b expected 0/111", t, spawn_pulse, active_mask);
        end
      end
      if (t == 844) begin
        checks++;
        if (active_mask !== 3'b110) begin
          errors++;
          $display("[TB] FAIL full_retire_slot0: got %b expected 110", active_mask);
        end
      end
      if (t == 907) begin
        checks++;
        if ({spawn_pulse, active_mask} !== {1'b1, 3'b111}) begin
          errors++;
          $display("[TB] FAIL full_respawn_tick907: got %b/%b expected 1/111", spawn_pulse, active_mask);
        end
      end
    end
  endtask

  task automatic test_retire();
    apply_stimulus(0, 0, 1, 1, 40, 0, 0);
    for (int t = 1; t <= 151; t++) apply_stimulus(0, 1, 1, 0, 40, 0, 0);
    for (int t = 1; t <= 542; t++) apply_stimulus(0, 1, 1, 0, 5, 0, 0);
    apply_stimulus(0, 1, 0, 0, 5, 0, 0);
    for (int t = 1; t <= 149; t++) begin
      apply_stimulus(0, 1, 1, 0, 5, 0, 199);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL retire_approach_tick%0d: got %h expected %h", t, obs_vec, exp_vec());
      end
    end
    apply_stimulus(0, 0, 1, 0, 5, 0, 199);
    checks++;
    if ({pix_valid, pix_addr} !== {1'b1, 11'd987}) begin
      errors++;
      $display("[TB] FAIL retire_clip_x1: got %b/%0d expected 1/987", pix_valid, pix_addr);
    end
    apply_stimulus(0, 1, 1, 0, 5, 0, 199);
    apply_stimulus(0, 0, 1, 0, 5, 0, 199);
    checks++;
    if ({pix_valid, active_mask} !== {1'b0, 3'b001}) begin
      errors++;
      $display("[TB] FAIL retire_x0: got %b/%b expected 0/001", pix_valid, active_mask);
    end
    apply_stimulus(0, 1, 1, 0, 40, 0, 0);
    checks++;
    if ({spawn_pulse, active_mask} !== {1'b1, 3'b010}) begin
      errors++;
      $display("[TB] FAIL retire_no_reuse: got %b/%b expected 1/010", spawn_pulse, active_mask);
    end
  endtask

  task automatic test_pixel();
    int ph [6] = '{248, 299, 300, 247, 260, 260};
    int pv [6] = '{181, 199, 199, 190, 180, 200};
    int ok [6] = '{1, 1, 0, 0, 0, 0};
    int pa [6] = '{0, 987, 0, 0, 0, 0};
    apply_stimulus(0, 0, 1, 1, 40, 0, 0);
    for (int t = 1; t <= 151; t++) apply_stimulus(0, 1, 1, 0, 40, 0, 0);
    for (int t = 1; t <= 392; t++) apply_stimulus(0, 1, 1, 0, 5, 0, 0);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(0, 0, 1, 0, 5, ph[k], pv[k]);
      checks++;
      if ({pix_valid, pix_addr, pix_slot} !== {1'(ok[k]), 11'(pa[k]), 3'd0}) begin
        errors++;
        $display("[TB] FAIL pixel_probe(%0d,%0d): got %b/%0d/%0d expected %0d/%0d/0",
                 ph[k], pv[k], pix_valid, pix_addr, pix_slot, ok[k], pa[k]);
      end
    end
  endtask

  task automatic test_run_freeze();
    for (int t = 1; t <= 20; t++) begin
      apply_stimulus(0, 1, 0, 0, 40, 299, 199);
      checks++;
      if ({pix_valid, pix_addr} !== {1'b1, 11'd987}) begin
        errors++;
        $display("[TB] FAIL freeze_pos_tick%0d: got %b/%0d expected 1/987", t, pix_valid, pix_addr);
      end
    end
    for (int t = 1; t <= 151; t++) begin
      apply_stimulus(0, 1, 1, 0, 40, 0, 0);
      checks++;
      if (spawn_pulse !== (t == 151)) begin
        errors++;
        $display("[TB] FAIL freeze_gap_tick%0d: got %b expected %b", t, spawn_pulse, t == 151);
      end
    end
    checks++;
    if (active_mask !== 3'b011) begin
      errors++;
      $display("[TB] FAIL freeze_spawn_mask: got %b expected 011", active_mask);
    end
    apply_stimulus(0, 1, 1, 1, 40, 691, 199);
    checks++;
    if ({active_mask, pix_valid, pix_addr} !== {3'b000, 1'b1, 11'd987}) begin
      errors++;
      $display("[TB] FAIL clear_cycle: got %b/%b/%0d expected 000/1/987", active_mask, pix_valid, pix_addr);
    end
    apply_stimulus(0, 0, 1, 0, 40, 691, 199);
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_pix_after: got %b expected 0", pix_valid);
    end
  endtask

  task automatic test_random();
    int h, v;
    bit mt, rn, cl;
    for (int t = 0; t < 3000; t++) begin
      mt = ($urandom_range(0, 1) == 1);
      rn = ($urandom_range(0, 19) != 0);
      cl = ($urandom_range(0, 499) == 0);
      pick_probe(h, v);
      apply_stimulus(0, mt, rn, cl, int'($urandom_range(0, 127)), h, v);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", t, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 400; t++) apply_stimulus(0, 1, 1, 0, 60, 0, 0);
    apply_stimulus(1, 1, 1, 0, 60, 691, 199);
    checks++;
    if (obs_vec !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %h expected %h", obs_vec, 19'd0);
    end
  endtask

  task automatic test_overlap();
    b_cycle(1, 0, 0, 0);
    for (int t = 1; t <= 62; t++) begin
      b_cycle(0, 1, 0, 0);
      if (t == 30 || t == 31 || t == 62) begin
        checks++;
        if (b_spawn !== (t != 30)) begin
          errors++;
          $display("[TB] FAIL overlap_spawn_tick%0d: got %b expected %b", t, b_spawn, t != 30);
        end
      end
    end
    checks++;
    if (b_mask !== 3'b011) begin
      errors++;
      $display("[TB] FAIL overlap_mask: got %b expected 011", b_mask);
    end
    b_cycle(0, 0, 650, 190);
    checks++;
    if ({b_valid, b_slot, b_addr} !== {1'b1, 3'd0, 11'd509}) begin
      errors++;
      $display("[TB] FAIL overlap_winner: got %b/%0d/%0d expected 1/0/509", b_valid, b_slot, b_addr);
    end
    b_cycle(0, 0, 670, 190);
    checks++;
    if ({b_valid, b_slot, b_addr} !== {1'b1, 3'd1, 11'd498}) begin
      errors++;
      $display("[TB] FAIL overlap_slot1_only: got %b/%0d/%0d expected 1/1/498", b_valid, b_slot, b_addr);
    end
    b_cycle(0, 0, 640, 190);
    checks++;
    if ({b_valid, b_slot, b_addr} !== {1'b1, 3'd0, 11'd499}) begin
      errors++;
      $display("[TB] FAIL overlap_edge: got %b/%0d/%0d expected 1/0/499", b_valid, b_slot, b_addr);
    end
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; run = 1'b0; clear = 1'b0;
    rand_in = '0; h_cnt = '0; v_cnt = '0;
    b_rst = 1'b1; b_move = 1'b0; b_run = 1'b1; b_clear = 1'b0;
    b_rand = 7'd40; b_h = '0; b_v = '0;
    model_reset();
    e_valid = 0; e_addr = 0; e_slot = 0; e_spawn = 0;

    test_reset();
    test_spawn();
    test_skip();
    test_full();
    test_retire();
    test_pixel();
    test_run_freeze();
    test_random();
    test_reset_mid();
    test_overlap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
